// File: rtl/adrv9001_tx_sched.sv
// adrv9001_tx_sched: timed burst scheduler for one ADRV9001 TX channel.
// Optional status counters are built when ADRV9001_TX_SCHED_STATUS_EN is defined.
module adrv9001_tx_sched #(
    parameter int CMD_FIFO_AW  = 3,
    parameter int TAIL_SAMPLES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [47:0] s_cmd_tdata,
    input  logic        s_cmd_tvalid,
    output logic        s_cmd_tready,
    input  logic        abort,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        tx_enable,
    output logic [31:0] timestamp,
    output logic        busy,
    output logic        late_err,
    output logic [15:0] burst_cnt,
    output logic [15:0] underflow_cnt
);

    localparam int          DEPTH  = 1 << CMD_FIFO_AW;
    localparam logic [15:0] TAIL16 = 16'(TAIL_SAMPLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_TAIL
    } state_t;

    state_t               state_q, state_d;
    logic                 ce_q;
    logic [31:0]          ts_q;
    logic                 init_q;
    logic [47:0]          mem_q [DEPTH];
    logic [CMD_FIFO_AW:0] wr_q, rd_q;
    logic [31:0]          start_q, start_d;
    logic [15:0]          rem_q, rem_d;
    logic [15:0]          tail_q, tail_d;
    logic                 txen_q, txen_d;
    logic                 late_q, late_d;

    logic        full, empty, push, pop;
    logic        in_burst, hs, is_late;
    logic [47:0] head;
    logic [15:0] head_len;
    logic [31:0] head_start, diff;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[CMD_FIFO_AW] != rd_q[CMD_FIFO_AW]) &&
                   (wr_q[CMD_FIFO_AW-1:0] == rd_q[CMD_FIFO_AW-1:0]);

    assign s_cmd_tready = init_q && !full && !abort;
    assign push         = s_cmd_tvalid && s_cmd_tready;
    assign pop          = (state_q == S_IDLE) && !empty && !abort;

    assign head       = mem_q[rd_q[CMD_FIFO_AW-1:0]];
    assign head_len   = head[47:32];
    assign head_start = head[31:0];
    // Signed mod-2^32 distance: zero or negative means the start is already past.
    assign diff       = head_start - ts_q;
    assign is_late    = (diff == 32'd0) || diff[31];

    assign in_burst = (state_q == S_BURST);
    assign hs       = s_axis_tvalid && m_axis_tready;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = in_burst && s_axis_tvalid;
    assign s_axis_tready = in_burst && m_axis_tready;

    assign tx_enable = txen_q;
    assign timestamp = ts_q;
    assign late_err  = late_q;
    assign busy      = (state_q != S_IDLE) || !empty;

    // Command storage; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[CMD_FIFO_AW-1:0]] <= s_cmd_tdata;
        end
    end

    // FIFO pointers; abort flushes the queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (abort) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Sample-rate tick and free-running sample counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ce_q   <= 1'b0;
            ts_q   <= '0;
            init_q <= 1'b0;
        end else begin
            ce_q   <= ~ce_q;
            ts_q   <= ts_q + {31'b0, ce_q};
            init_q <= 1'b1;
        end
    end

    // Scheduler next-state logic.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        rem_d   = rem_q;
        tail_d  = tail_q;
        txen_d  = txen_q;
        late_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pop && head_len != 16'd0) begin
                    if (is_late) begin
                        late_d = 1'b1;
                    end else begin
                        start_d = head_start;
                        rem_d   = head_len;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ce_q && ts_q == start_q) begin
                    txen_d  = 1'b1;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (hs) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        tail_d  = TAIL16;
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (tail_q == 16'd0) begin
                    txen_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (ce_q) begin
                    tail_d = tail_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            txen_d  = 1'b0;
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            start_q <= '0;
            rem_q   <= '0;
            tail_q  <= '0;
            txen_q  <= 1'b0;
            late_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            rem_q   <= rem_d;
            tail_q  <= tail_d;
            txen_q  <= txen_d;
            late_q  <= late_d;
        end
    end

`ifdef ADRV9001_TX_SCHED_STATUS_EN
    logic [15:0] bcnt_q, ucnt_q;
    logic        burst_done, uf_ev;

    assign burst_done = (state_q == S_TAIL) && (tail_q == 16'd0) && !abort;
    assign uf_ev      = in_burst && m_axis_tready && !s_axis_tvalid;

    // Completed-burst (wrapping) and underflow (saturating) counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcnt_q <= '0;
            ucnt_q <= '0;
        end else begin
            if (burst_done) bcnt_q <= bcnt_q + 16'd1;
            if (uf_ev && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign burst_cnt     = bcnt_q;
    assign underflow_cnt = ucnt_q;
`else
    assign burst_cnt     = '0;
    assign underflow_cnt = '0;
`endif

endmodule
